// File: rtl/ca_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ca_cmd_arbiter
// Brief   : Round-robin CA command arbiter with two-beat lock, rank-switch
//           gap enforcement and a registered output stage.
// Revision: 1.0 - initial release
// ============================================================================
module ca_cmd_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int CA_WIDTH     = 24,
    parameter int RANK_BITS    = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int LOCK_TIMEOUT = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_enable,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*CA_WIDTH-1:0]   i_req_ca,
    input  logic [NUM_REQ*RANK_BITS-1:0]  i_req_rank,
    input  logic [NUM_REQ-1:0]            i_req_two_beat,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [CA_WIDTH-1:0]           o_out_ca,
    output logic [RANK_BITS-1:0]          o_out_rank,
    output logic [$clog2(NUM_REQ)-1:0]    o_out_src,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic                          o_busy,
    output logic                          o_lock_err,
    output logic [31:0]                   o_issued_count,
    output logic [31:0]                   o_gap_count,
    output logic [31:0]                   o_err_count
);

    localparam int        c_SRC_W     = $clog2(NUM_REQ);
    localparam logic [3:0] c_GAP      = 4'(GAP_CYCLES);
    localparam logic [7:0] c_LOCK_LAST = 8'(LOCK_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_SRC_W-1:0]   r_rr_ptr;
    logic [c_SRC_W-1:0]   r_lock_idx;
    logic [3:0]           r_gap_cnt;
    logic [7:0]           r_lock_wait;
    logic [RANK_BITS-1:0] r_last_rank;
    logic                 r_last_vld;
    logic [CA_WIDTH-1:0]  r_out_ca;
    logic [RANK_BITS-1:0] r_out_rank;
    logic [c_SRC_W-1:0]   r_out_src;
    logic                 r_out_valid;
    logic                 r_lock_err;
    logic [31:0]          r_issued_count;
    logic [31:0]          r_gap_count;
    logic [31:0]          r_err_count;

    logic [CA_WIDTH-1:0]  w_ca   [NUM_REQ];
    logic [RANK_BITS-1:0] w_rank [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_ca[g]   = i_req_ca[g*CA_WIDTH +: CA_WIDTH];
        assign w_rank[g] = i_req_rank[g*RANK_BITS +: RANK_BITS];
    end

    function automatic logic [c_SRC_W-1:0] f_next(input logic [c_SRC_W-1:0] idx);
        return (idx == c_SRC_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Scan offsets from highest to lowest so the nearest valid index to rr_ptr wins.
    logic               w_any;
    logic [c_SRC_W-1:0] w_win;
    logic [c_SRC_W:0]   w_cand;
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, r_rr_ptr} + (c_SRC_W+1)'(k);
            if (w_cand >= (c_SRC_W+1)'(NUM_REQ))
                w_cand = w_cand - (c_SRC_W+1)'(NUM_REQ);
            if (i_req_valid[w_cand[c_SRC_W-1:0]]) begin
                w_any = 1'b1;
                w_win = w_cand[c_SRC_W-1:0];
            end
        end
    end

    logic               w_load_ok;
    logic               w_gap_ok;
    logic               w_arb_try;
    logic               w_arb_acc;
    logic               w_gap_stall;
    logic               w_lock_acc;
    logic               w_acc;
    logic [c_SRC_W-1:0] w_sel;
    logic [NUM_REQ-1:0] w_ready;

    assign w_load_ok   = !r_out_valid || i_out_ready;
    assign w_gap_ok    = !r_last_vld || (w_rank[w_win] == r_last_rank) || (r_gap_cnt == 4'd0);
    assign w_arb_try   = rst_n && (r_state == ST_ARB) && w_any && i_enable && w_load_ok;
    assign w_arb_acc   = w_arb_try && w_gap_ok;
    assign w_gap_stall = w_arb_try && !w_gap_ok;
    assign w_lock_acc  = rst_n && (r_state == ST_LOCK) && i_req_valid[r_lock_idx] && w_load_ok;
    assign w_acc       = w_arb_acc || w_lock_acc;
    assign w_sel       = (r_state == ST_LOCK) ? r_lock_idx : w_win;

    always_comb begin
        w_ready = '0;
        if (w_acc)
            w_ready[w_sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_ARB;
            r_rr_ptr       <= '0;
            r_lock_idx     <= '0;
            r_gap_cnt      <= '0;
            r_lock_wait    <= '0;
            r_last_rank    <= '0;
            r_last_vld     <= 1'b0;
            r_out_ca       <= '0;
            r_out_rank     <= '0;
            r_out_src      <= '0;
            r_out_valid    <= 1'b0;
            r_lock_err     <= 1'b0;
            r_issued_count <= '0;
            r_gap_count    <= '0;
            r_err_count    <= '0;
        end else begin
            if (w_acc) begin
                r_out_ca    <= w_ca[w_sel];
                r_out_rank  <= w_rank[w_sel];
                r_out_src   <= w_sel;
                r_out_valid <= 1'b1;
                r_last_rank <= w_rank[w_sel];
                r_last_vld  <= 1'b1;
                r_gap_cnt   <= c_GAP;
                if (r_issued_count != 32'hFFFF_FFFF)
                    r_issued_count <= r_issued_count + 32'd1;
            end else begin
                if (i_out_ready)
                    r_out_valid <= 1'b0;
                if (r_gap_cnt != 4'd0)
                    r_gap_cnt <= r_gap_cnt - 4'd1;
            end

            if (w_gap_stall && (r_gap_count != 32'hFFFF_FFFF))
                r_gap_count <= r_gap_count + 32'd1;

            case (r_state)
                ST_ARB: begin
                    if (w_arb_acc) begin
                        if (i_req_two_beat[w_win]) begin
                            r_state     <= ST_LOCK;
                            r_lock_idx  <= w_win;
                            r_lock_wait <= '0;
                        end else begin
                            r_rr_ptr <= f_next(w_win);
                        end
                    end
                end
                ST_LOCK: begin
                    if (w_lock_acc) begin
                        r_state  <= ST_ARB;
                        r_rr_ptr <= f_next(r_lock_idx);
                    end else if (!i_req_valid[r_lock_idx]) begin
                        // The cycle that brings the miss count to LOCK_TIMEOUT abandons the command.
                        if (r_lock_wait == c_LOCK_LAST) begin
                            r_state    <= ST_ARB;
                            r_rr_ptr   <= f_next(r_lock_idx);
                            r_lock_err <= 1'b1;
                            if (r_err_count != 32'hFFFF_FFFF)
                                r_err_count <= r_err_count + 32'd1;
                        end else begin
                            r_lock_wait <= r_lock_wait + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_req_ready    = w_ready;
    assign o_out_ca       = r_out_ca;
    assign o_out_rank     = r_out_rank;
    assign o_out_src      = r_out_src;
    assign o_out_valid    = r_out_valid;
    assign o_busy         = (r_state == ST_LOCK) || r_out_valid;
    assign o_lock_err     = r_lock_err;
    assign o_issued_count = r_issued_count;
    assign o_gap_count    = r_gap_count;
    assign o_err_count    = r_err_count;

endmodule
`default_nettype wire

// File: doc/ca_cmd_arbiter.md
CA_CMD_ARBITER -- requirements
Module: ca_cmd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of CA command requesters; legal range 2..8.
REQ-002 Parameter CA_WIDTH, default 24: CA word width.
REQ-003 Parameter RANK_BITS, default 4: rank tag width.
REQ-004 Parameter GAP_CYCLES, default 2: minimum idle cycles between accepted beats of different rank; legal range 0..15.
REQ-005 Parameter LOCK_TIMEOUT, default 8: cycles LOCK tolerates a missing second beat; legal range 1..255.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 enable  input  1  permits new command grants.
REQ-009 req_valid  input  NUM_REQ  per-requester beat valid.
REQ-010 req_ca  input  NUM_REQ x CA_WIDTH  per-requester CA beat.
REQ-011 req_rank  input  NUM_REQ x RANK_BITS  per-requester target rank.
REQ-012 req_two_beat  input  NUM_REQ  current beat is the first beat of a two-beat command.
REQ-013 req_ready  output  NUM_REQ  beat accepted this cycle; one-hot or zero.
REQ-014 out_ca  output  CA_WIDTH  registered CA beat to the distributor.
REQ-015 out_rank  output  RANK_BITS  rank of out_ca.
REQ-016 out_src  output  clog2(NUM_REQ)  index of the requester that sourced out_ca.
REQ-017 out_valid  output  1  out_ca valid.
REQ-018 out_ready  input  1  distributor accepts out_ca.
REQ-019 busy  output  1  high while state is LOCK or out_valid is high.
REQ-020 lock_err  output  1  sticky: LOCK timed out.
REQ-021 issued_count, gap_count, err_count  output  32 each  accepted beats, rank-gap stall cycles, lock timeouts.

Function
REQ-022 Output register loads only when load_ok = !out_valid || out_ready; out_valid clears when out_ready is high and nothing loads.
REQ-023 An accept in cycle t (req_ready[i]=1 and load_ok) drives out_ca/out_rank/out_src in cycle t+1 with out_valid=1.
REQ-024 FSM states: ARB and LOCK.
REQ-025 In ARB, the winner is the first index at or after rr_ptr (modulo NUM_REQ) with req_valid high; the choice does not depend on rank.
REQ-026 In ARB, the winner is accepted only when enable=1, load_ok=1, and the rank gap is satisfied.
REQ-027 Rank gap is satisfied when no beat has been accepted since reset, or winner rank == last_rank, or gap_cnt == 0.
REQ-028 gap_cnt loads GAP_CYCLES on every accept and otherwise decrements once per cycle, saturating at 0.
REQ-029 A winner blocked only by the rank gap stalls arbitration with no requester bypass, and gap_count increments each such cycle.
REQ-030 On an ARB accept with req_two_beat=1, state goes to LOCK, lock_idx takes the winner, and rr_ptr is unchanged.
REQ-031 On an ARB accept with req_two_beat=0, rr_ptr becomes (winner+1) mod NUM_REQ.
REQ-032 In LOCK, only req_ready[lock_idx] may assert, when req_valid[lock_idx] and load_ok are both high.
REQ-033 LOCK ignores enable, rank gap and req_two_beat.
REQ-034 A LOCK accept returns the FSM to ARB and sets rr_ptr to (lock_idx+1) mod NUM_REQ.
REQ-035 lock_wait counts LOCK cycles with req_valid[lock_idx]=0 and clears on LOCK entry.
REQ-036 When lock_wait reaches LOCK_TIMEOUT, the FSM returns to ARB with no accept; lock_err sets, err_count increments, and rr_ptr becomes (lock_idx+1) mod NUM_REQ.
REQ-037 last_rank updates on every accepted beat, first or second.
REQ-038 issued_count increments per accepted beat; all counters saturate at 32'hFFFF_FFFF.
REQ-039 Deasserting enable blocks ARB grants only; it never affects the output register drain or an open LOCK.

Reset
REQ-040 While rst_n is low, req_ready, out_ca, out_rank, out_src, out_valid, busy, lock_err and all counters are 0.
REQ-041 While rst_n is low, state is ARB, rr_ptr, gap_cnt and lock_wait are 0, and last_rank is marked invalid.
REQ-042 Reset asserted mid-LOCK or mid-gap aborts the command with no error counted.

Verification
REQ-043 All three requesters valid, single-beat, rank 0, out_ready=1 -> out_src 0,1,2,0 on consecutive cycles; issued_count=4.
REQ-044 req1 two-beat with req0 and req2 valid -> req1 beats appear back-to-back in out_ca, then req2, then req0.
REQ-045 GAP_CYCLES=2: req0 rank0 accepted at t, then only req1 rank1 valid -> req1 accepted at t+3, out_valid at t+1 and t+4, gap_count=2.
REQ-046 out_ready=0 for 5 cycles with out_valid=1 -> req_ready=0, out_ca stable; out_ready=1 -> next beat loads the same cycle.
REQ-047 LOCK_TIMEOUT=8: req1 first beat accepted, then req_valid[1]=0 -> ARB after 8 cycles, lock_err=1, err_count=1, next grant to req2.
REQ-048 rst_n pulsed low while in LOCK -> all outputs 0 and state ARB; the first grant after release goes to req0.
